trax_move_parser: RTL and testbench

- Sits directly downstream of the serial receiver; consumes its byte stream (rx_data / rx_finish).
- Parses one ASCII Trax move per line (column letter, 1-2 digit row, tile char, CR/LF terminator) into binary fields for the game engine.
- Presents each move with a valid/ready handshake.
- Flags malformed lines, overruns and inter-byte timeouts.

---
 rtl/trax_uart_pkg.sv | 59 +++++
 rtl/trax_move_parser_if.sv | 26 ++
 rtl/uart_idle_timer.sv | 28 ++
 rtl/trax_move_parser.sv | 141 ++++++++++++++
 tb/tb_trax_move_parser.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/trax_uart_pkg.sv
// Shared definitions for the Trax serial front end: ASCII codes, tile encodings,
// parser states and the byte-time formula also used by the serial receiver.
package trax_uart_pkg;

  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_AT     = 8'h40;
  localparam logic [7:0] ASCII_Z      = 8'h5A;
  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_9      = 8'h39;
  localparam logic [7:0] ASCII_PLUS   = 8'h2B;
  localparam logic [7:0] ASCII_SLASH  = 8'h2F;
  localparam logic [7:0] ASCII_BSLASH = 8'h5C;

  localparam logic [1:0] TILE_PLUS   = 2'd0;
  localparam logic [1:0] TILE_SLASH  = 2'd1;
  localparam logic [1:0] TILE_BSLASH = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ROW1,
    ROW2,
    TILE,
    EOL,
    SKIP,
    HOLD
  } parse_state_t;

  // One serial frame is 10 bit times (start, 8 data, stop).
  function automatic int unsigned byte_cycles(input int unsigned clk_rate,
                                              input int unsigned baud_rate);
    return (clk_rate / baud_rate) * 10;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_column(input logic [7:0] b);
    return (b >= ASCII_AT) && (b <= ASCII_Z);
  endfunction

  function automatic logic is_tile(input logic [7:0] b);
    return (b == ASCII_PLUS) || (b == ASCII_SLASH) || (b == ASCII_BSLASH);
  endfunction

  function automatic logic [1:0] tile_code(input logic [7:0] b);
    logic [1:0] code;
    code = TILE_PLUS;
    if (b == ASCII_SLASH)  code = TILE_SLASH;
    if (b == ASCII_BSLASH) code = TILE_BSLASH;
    return code;
  endfunction

  function automatic logic state_is_busy(input parse_state_t s);
    return (s == ROW1) || (s == ROW2) || (s == TILE) || (s == EOL) || (s == SKIP);
  endfunction

endpackage

// File: rtl/trax_move_parser_if.sv
// Parsed-move handshake between the move parser and the game engine.
interface trax_move_parser_if;

  logic       move_valid;
  logic       move_ready;
  logic [4:0] move_col;
  logic [6:0] move_row;
  logic [1:0] move_tile;

  modport master (
    output move_valid,
    output move_col,
    output move_row,
    output move_tile,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_col,
    input  move_row,
    input  move_tile,
    output move_ready
  );

endinterface

// File: rtl/uart_idle_timer.sv
// Saturating silence counter: clear restarts it, enable lets it advance,
// expired stays high once the limit is reached until the next clear.
module uart_idle_timer #(
  parameter int unsigned limit = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(limit + 1);
  localparam logic [W-1:0] LIMIT_C = W'(limit);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_C)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LIMIT_C);

endmodule

// File: rtl/trax_move_parser.sv
// Turns the receiver byte stream into Trax moves ("A12/" CR LF -> col/row/tile)
// and flags malformed lines, overruns and mid-line silence.
module trax_move_parser
  import trax_uart_pkg::*;
#(
  parameter int unsigned clk_rate      = 9600000,
  parameter int unsigned baud_rate     = 9600,
  parameter int unsigned timeout_bytes = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_finish,
  trax_move_parser_if.master        move,
  output logic                      parse_error,
  output logic                      busy
);

  localparam int unsigned TIMEOUT_CYCLES = byte_cycles(clk_rate, baud_rate) * timeout_bytes;

  parse_state_t state;
  logic         rx_finish_q;
  logic         strobe;
  logic         counting;
  logic         timed_out;

  // NOTE: the previous-value register resets to 1 because the receiver idles
  // with rx_finish high; resetting it to 0 would fake a byte right after reset.
  always_ff @(posedge clk) begin
    if (reset) rx_finish_q <= 1'b1;
    else       rx_finish_q <= rx_finish;
  end

  assign strobe   = rx_finish && !rx_finish_q;
  assign counting = (state == ROW1) || (state == ROW2) || (state == TILE) || (state == EOL);

  uart_idle_timer #(
    .limit (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (strobe),
    .enable  (counting),
    .expired (timed_out)
  );

  // NOTE: these tasks only run from the clocked block below, so they use
  // non-blocking assignments like the rest of the sequential state.
  task automatic go(input parse_state_t s);
    state <= s;
    busy  <= state_is_busy(s);
  endtask

  // An error on the terminating LF has nothing left to skip.
  task automatic fail(input logic [7:0] b);
    parse_error <= 1'b1;
    go((b == ASCII_LF) ? IDLE : SKIP);
  endtask

  task automatic idle_byte(input logic [7:0] b);
    if ((b == ASCII_CR) || (b == ASCII_LF)) begin
      go(IDLE);
    end else if (is_column(b)) begin
      move.move_col <= 5'(b - ASCII_AT);
      go(ROW1);
    end else begin
      fail(b);
    end
  endtask

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      parse_error     <= 1'b0;
      move.move_valid <= 1'b0;
      move.move_col   <= '0;
      move.move_row   <= '0;
      move.move_tile  <= '0;
    end else begin
      parse_error <= 1'b0;
      if (state == HOLD) begin
        // A byte arriving with the accept is the first byte of the next line.
        if (move.move_ready) begin
          move.move_valid <= 1'b0;
          if (strobe) idle_byte(rx_data);
          else        go(IDLE);
        end else if (strobe) begin
          parse_error <= 1'b1;
        end
      end else if (strobe) begin
        unique case (state)
          IDLE: idle_byte(rx_data);
          ROW1: begin
            if (is_digit(rx_data)) begin
              move.move_row <= 7'(rx_data[3:0]);
              go(ROW2);
            end else begin
              fail(rx_data);
            end
          end
          ROW2: begin
            if (is_digit(rx_data)) begin
              move.move_row <= (move.move_row * 7'd10) + 7'(rx_data[3:0]);
              go(TILE);
            end else if (is_tile(rx_data)) begin
              move.move_tile <= tile_code(rx_data);
              go(EOL);
            end else begin
              fail(rx_data);
            end
          end
          TILE: begin
            if (is_tile(rx_data)) begin
              move.move_tile <= tile_code(rx_data);
              go(EOL);
            end else begin
              fail(rx_data);
            end
          end
          EOL: begin
            if (rx_data == ASCII_LF) begin
              move.move_valid <= 1'b1;
              go(HOLD);
            end else if (rx_data != ASCII_CR) begin
              fail(rx_data);
            end
          end
          SKIP: begin
            if (rx_data == ASCII_LF) go(IDLE);
          end
          default: go(IDLE);
        endcase
      end else if (timed_out && counting) begin
        parse_error <= 1'b1;
        go(IDLE);
      end
    end
  end

endmodule

// File: tb/tb_trax_move_parser.sv
// Scoreboard bench for trax_move_parser: expected moves are queued as lines are
// sent and compared when the parser hands a move over.
module tb_trax_move_parser;
  import trax_uart_pkg::*;

  localparam int unsigned CLK_RATE  = 96000;
  localparam int unsigned BAUD_RATE = 9600;
  localparam int unsigned TO_BYTES  = 1;

  typedef struct packed {
    logic [4:0] col;
    logic [6:0] row;
    logic [1:0] tile;
  } move_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_finish = 1'b1;
  logic       parse_error;
  logic       busy;

  int    n_checks = 0;
  int    n_errs = 0;
  int    err_pulses = 0;
  logic  err_prev = 1'b0;
  move_t sb[$];

  trax_move_parser_if move_if ();

  trax_move_parser #(
    .clk_rate      (CLK_RATE),
    .baud_rate     (BAUD_RATE),
    .timeout_bytes (TO_BYTES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_finish   (rx_finish),
    .move        (move_if),
    .parse_error (parse_error),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: counts error pulses and scores every accepted move.
  always @(negedge clk) begin
    if (!reset) begin
      if (parse_error) begin
        check("err_pulse_width", err_prev, 0);
        err_pulses <= err_pulses + 1;
      end
      err_prev <= parse_error;
      if (move_if.move_valid && move_if.move_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_move", move_if.move_valid, 0);
        end else begin
          move_t e;
          e = sb.pop_front();
          check("mv_col", move_if.move_col, e.col);
          check("mv_row", move_if.move_row, e.row);
          check("mv_tile", move_if.move_tile, e.tile);
        end
      end
    end
  end

  task automatic push_move(input int c, input int r, input int t);
    move_t m;
    m.col  = 5'(c);
    m.row  = 7'(r);
    m.tile = 2'(t);
    sb.push_back(m);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit raise_ready = 1'b0);
    @(posedge clk); #1;
    rx_finish = 1'b0;
    rx_data   = b;
    repeat (2) @(posedge clk);
    #1;
    rx_finish = 1'b1;
    if (raise_ready) move_if.move_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_line(input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    if (crlf) send_byte(ASCII_CR);
    send_byte(ASCII_LF);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 100 && !move_if.move_valid; k++) @(negedge clk);
    check(tag, move_if.move_valid, 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int e0;
    move_if.move_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", move_if.move_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", parse_error, 0);
    check("rst_col", move_if.move_col, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // "A12/" CR LF held until accepted
    push_move(1, 12, 1);
    send_byte("A");
    @(negedge clk);
    check("t1_busy_mid", busy, 1);
    send_line("12/", 1'b1);
    wait_valid("t1_valid");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_hold_valid", move_if.move_valid, 1);
      check("t1_hold_col", move_if.move_col, 1);
      check("t1_hold_row", move_if.move_row, 12);
      check("t1_hold_tile", move_if.move_tile, 1);
    end
    check("t1_hold_busy", busy, 0);
    @(posedge clk); #1;
    move_if.move_ready = 1'b1;
    @(posedge clk); #1;
    move_if.move_ready = 1'b0;
    @(negedge clk);
    check("t1_valid_low", move_if.move_valid, 0);
    check("t1_busy_low", busy, 0);
    check("t1_sb", sb.size(), 0);

    // Back-to-back moves, boundary columns/rows, ready tied high
    move_if.move_ready = 1'b1;
    e0 = err_pulses;
    push_move(0, 0, 0);
    send_line("@0+", 1'b0);
    push_move(26, 99, 2);
    send_line("Z99\\", 1'b0);
    wait_drain("t2_drain");
    check("t2_no_err", err_pulses - e0, 0);

    // Malformed tile char, rest of line skipped
    e0 = err_pulses;
    send_line("A1x", 1'b0);
    push_move(2, 3, 0);
    send_line("B3+", 1'b0);
    wait_drain("t3_drain");
    check("t3_err", err_pulses - e0, 1);

    // Overrun while holding, then accept coincident with next strobe
    move_if.move_ready = 1'b0;
    e0 = err_pulses;
    push_move(3, 4, 0);
    send_line("C4+", 1'b0);
    wait_valid("t4_valid");
    send_byte("D");
    @(negedge clk);
    check("t4_overrun_err", err_pulses - e0, 1);
    check("t4_still_valid", move_if.move_valid, 1);
    check("t4_held_col", move_if.move_col, 3);
    check("t4_held_row", move_if.move_row, 4);
    push_move(5, 5, 0);
    send_byte("E", 1'b1);
    @(negedge clk);
    check("t4_after_accept_valid", move_if.move_valid, 0);
    check("t4_after_accept_busy", busy, 1);
    check("t4_after_accept_col", move_if.move_col, 5);
    send_line("5+", 1'b0);
    wait_drain("t4_drain");
    check("t4_err_total", err_pulses - e0, 1);

    // Mid-line silence of one byte time aborts the line
    e0 = err_pulses;
    send_byte("A");
    send_byte("1");
    repeat (90) @(posedge clk);
    check("t5_no_early_err", err_pulses - e0, 0);
    check("t5_busy_waiting", busy, 1);
    for (int k = 0; k < 40 && err_pulses == e0; k++) @(posedge clk);
    check("t5_timeout_err", err_pulses - e0, 1);
    @(negedge clk);
    check("t5_idle_after", busy, 0);
    push_move(2, 2, 0);
    send_line("B2+", 1'b0);
    wait_drain("t5_drain");
    check("t5_err_total", err_pulses - e0, 1);

    // Reset mid-line drops the partial move
    e0 = err_pulses;
    send_byte("A");
    send_byte("5");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_rst_valid", move_if.move_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_col", move_if.move_col, 0);
    check("t6_rst_row", move_if.move_row, 0);
    repeat (3) @(posedge clk);
    check("t6_no_strobe_busy", busy, 0);
    check("t6_no_err", err_pulses - e0, 0);
    push_move(1, 5, 1);
    send_line("A5/", 1'b0);
    wait_drain("t6_drain");
    check("t6_err_total", err_pulses - e0, 0);

    repeat (5) @(posedge clk);
    check("final_sb", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
